// File: rtl/h_read_master_pkg.sv
// Shared AHB/AXI encodings and FSM state type for the h_read_master read bridge.
package h_read_master_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_INCR   = 3'b001;

   localparam logic [1:0] RESP_OKAY     = 2'b00;
   localparam logic [1:0] RESP_SLVERR   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_HOLD
   } state_e;

endpackage

// File: rtl/h_rd_data_slice.sv
// R-channel holding register: captures one AHB beat and presents it until the AXI handshake.
module h_rd_data_slice
   import h_read_master_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [1:0]        resp_i,
   input  logic              last_i,
   input  logic [ID_W-1:0]   id_i,
   output logic              r_valid_o,
   output logic [DATA_W-1:0] r_data_o,
   output logic [1:0]        r_resp_o,
   output logic              r_last_o,
   output logic [ID_W-1:0]   r_id_o
);

   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic [1:0]        resp_q;
   logic              last_q;
   logic [ID_W-1:0]   id_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         resp_q  <= RESP_OKAY;
         last_q  <= 1'b0;
         id_q    <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         resp_q  <= resp_i;
         last_q  <= last_i;
         id_q    <= id_i;
      end else if (pop_i) begin
         // r_last must drop with r_valid; data/resp/id simply persist
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end
   end

   assign r_valid_o = valid_q;
   assign r_data_o  = data_q;
   assign r_resp_o  = resp_q;
   assign r_last_o  = last_q;
   assign r_id_o    = id_q;

endmodule

// File: rtl/h_read_master.sv
// AXI read-address/read-data to AHB-Lite read master, one beat at a time, one burst outstanding.
// Optional macro H_READ_ERR_EN: forward hresp as SLVERR on the affected beat.
module h_read_master
   import h_read_master_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              ar_valid,
   output logic              ar_ready,
   input  logic [ADDR_W-1:0] ar_addr,
   input  logic [3:0]        ar_len,
   input  logic [2:0]        ar_size,
   input  logic [ID_W-1:0]   ar_id,
   output logic [ADDR_W-1:0] haddr,
   output logic [1:0]        htrans,
   output logic [2:0]        hburst,
   output logic [2:0]        hsize,
   output logic              hwrite,
   input  logic [DATA_W-1:0] hrdata,
   input  logic              hready,
   input  logic              hresp,
   output logic              r_valid,
   input  logic              r_ready,
   output logic [DATA_W-1:0] r_data,
   output logic [1:0]        r_resp,
   output logic              r_last,
   output logic [ID_W-1:0]   r_id
);

   state_e            state_q;
   logic [ADDR_W-1:0] start_q;
   logic [ADDR_W-1:0] haddr_q;
   logic [ADDR_W-1:0] haddr_d;
   logic [3:0]        len_q;
   logic [3:0]        beat_q;
   logic [3:0]        beat_d;
   logic [2:0]        size_q;
   logic [ID_W-1:0]   id_q;
   logic [1:0]        htrans_q;
   logic              ar_ready_q;
   logic              beat_last;
   logic              load;
   logic              pop;
   logic [1:0]        resp_d;

   assign beat_last = (beat_q == len_q);
   assign beat_d    = beat_q + 4'd1;
   // Address of the following beat, wrapping modulo 2^ADDR_W
   assign haddr_d   = start_q + (ADDR_W'(beat_d) << size_q);
   assign load      = (state_q == ST_DATA) && hready;
   assign pop       = (state_q == ST_HOLD) && r_ready;

`ifdef H_READ_ERR_EN
   assign resp_d = hresp ? RESP_SLVERR : RESP_OKAY;
`else
   assign resp_d = RESP_OKAY;
   logic unused_hresp;
   assign unused_hresp = hresp;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         ar_ready_q <= 1'b1;
         start_q    <= '0;
         haddr_q    <= '0;
         len_q      <= '0;
         beat_q     <= '0;
         size_q     <= '0;
         id_q       <= '0;
         htrans_q   <= HTRANS_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ar_valid) begin
                  state_q    <= ST_ADDR;
                  ar_ready_q <= 1'b0;
                  start_q    <= ar_addr;
                  haddr_q    <= ar_addr;
                  len_q      <= ar_len;
                  size_q     <= ar_size;
                  id_q       <= ar_id;
                  beat_q     <= '0;
                  htrans_q   <= HTRANS_NONSEQ;
               end
            end
            ST_ADDR: begin
               if (hready) begin
                  state_q  <= ST_DATA;
                  htrans_q <= HTRANS_IDLE;
               end
            end
            ST_DATA: begin
               if (hready) begin
                  state_q  <= ST_HOLD;
                  htrans_q <= beat_last ? HTRANS_IDLE : HTRANS_BUSY;
               end
            end
            ST_HOLD: begin
               if (r_ready) begin
                  if (beat_last) begin
                     state_q    <= ST_IDLE;
                     ar_ready_q <= 1'b1;
                     htrans_q   <= HTRANS_IDLE;
                  end else begin
                     state_q  <= ST_ADDR;
                     beat_q   <= beat_d;
                     haddr_q  <= haddr_d;
                     htrans_q <= HTRANS_SEQ;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ar_ready = ar_ready_q;
   assign haddr    = haddr_q;
   assign htrans   = htrans_q;
   assign hburst   = HBURST_INCR;
   assign hsize    = size_q;
   assign hwrite   = 1'b0;

   h_rd_data_slice #(
      .DATA_W (DATA_W),
      .ID_W   (ID_W)
   ) u_slice (
      .clk_i     (clk),
      .rst_ni    (resetn),
      .load_i    (load),
      .pop_i     (pop),
      .data_i    (hrdata),
      .resp_i    (resp_d),
      .last_i    (beat_last),
      .id_i      (id_q),
      .r_valid_o (r_valid),
      .r_data_o  (r_data),
      .r_resp_o  (r_resp),
      .r_last_o  (r_last),
      .r_id_o    (r_id)
   );

endmodule

// File: tb/tb_h_read_master.sv
// Directed self-checking bench for h_read_master; honours H_READ_ERR_EN when defined.
module tb_h_read_master;
   import h_read_master_pkg::*;

   logic        clk;
   logic        resetn;
   logic        ar_valid;
   logic        ar_ready;
   logic [31:0] ar_addr;
   logic [3:0]  ar_len;
   logic [2:0]  ar_size;
   logic [3:0]  ar_id;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic [2:0]  hburst;
   logic [2:0]  hsize;
   logic        hwrite;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;
   logic        r_valid;
   logic        r_ready;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        r_last;
   logic [3:0]  r_id;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

`ifdef H_READ_ERR_EN
   localparam logic [1:0] EXP_ERR_RESP = 2'b10;
`else
   localparam logic [1:0] EXP_ERR_RESP = 2'b00;
`endif

   h_read_master #(
      .ADDR_W (32),
      .DATA_W (32),
      .ID_W   (4)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .ar_valid (ar_valid),
      .ar_ready (ar_ready),
      .ar_addr  (ar_addr),
      .ar_len   (ar_len),
      .ar_size  (ar_size),
      .ar_id    (ar_id),
      .haddr    (haddr),
      .htrans   (htrans),
      .hburst   (hburst),
      .hsize    (hsize),
      .hwrite   (hwrite),
      .hrdata   (hrdata),
      .hready   (hready),
      .hresp    (hresp),
      .r_valid  (r_valid),
      .r_ready  (r_ready),
      .r_data   (r_data),
      .r_resp   (r_resp),
      .r_last   (r_last),
      .r_id     (r_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".ar_ready"}, ar_ready, 1);
      chk({tag, ".r_valid"},  r_valid, 0);
      chk({tag, ".r_last"},   r_last, 0);
      chk({tag, ".r_resp"},   r_resp, 0);
      chk({tag, ".r_data"},   r_data, 0);
      chk({tag, ".r_id"},     r_id, 0);
      chk({tag, ".htrans"},   htrans, 2'b00);
      chk({tag, ".haddr"},    haddr, 0);
      chk({tag, ".hsize"},    hsize, 0);
   endtask

   // Called at the negedge of an IDLE cycle; returns at the negedge of the beat-0 ADDR cycle.
   task automatic start_ar(input string tag, input logic [31:0] a, input logic [3:0] l,
                           input logic [2:0] s, input logic [3:0] id);
      chk({tag, ".ar_ready"}, ar_ready, 1);
      ar_valid = 1'b1;
      ar_addr  = a;
      ar_len   = l;
      ar_size  = s;
      ar_id    = id;
      @(negedge clk);
      ar_valid = 1'b0;
      chk({tag, ".ar_ready_busy"}, ar_ready, 0);
      chk({tag, ".hsize"}, hsize, s);
   endtask

   // Called at the negedge of an ADDR cycle; runs ADDR/DATA/HOLD with no stalls.
   task automatic do_beat(input string tag, input logic [31:0] ea, input logic [1:0] et,
                          input logic [31:0] d, input logic hr, input logic el,
                          input logic [1:0] er, input logic [1:0] eht, input logic [3:0] eid);
      chk({tag, ".haddr"}, haddr, ea);
      chk({tag, ".htrans"}, htrans, et);
      chk({tag, ".r_valid_addr"}, r_valid, 0);
      hready = 1'b1;
      @(negedge clk);
      chk({tag, ".htrans_data"}, htrans, 2'b00);
      hrdata = d;
      hresp  = hr;
      @(negedge clk);
      hresp  = 1'b0;
      chk({tag, ".r_valid"}, r_valid, 1);
      chk({tag, ".r_data"}, r_data, d);
      chk({tag, ".r_last"}, r_last, el);
      chk({tag, ".r_resp"}, r_resp, er);
      chk({tag, ".r_id"}, r_id, eid);
      chk({tag, ".htrans_hold"}, htrans, eht);
      r_ready = 1'b1;
      @(negedge clk);
      r_ready = 1'b0;
   endtask

   initial begin
      resetn   = 1'b0;
      ar_valid = 1'b0;
      ar_addr  = '0;
      ar_len   = '0;
      ar_size  = '0;
      ar_id    = '0;
      hrdata   = '0;
      hready   = 1'b1;
      hresp    = 1'b0;
      r_ready  = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset("rst");
      chk("rst.hburst", hburst, 3'b001);
      chk("rst.hwrite", hwrite, 0);
      resetn = 1'b1;
      @(negedge clk);

      // 4-beat word burst
      start_ar("b4", 32'h1000, 4'd3, 3'd2, 4'h5);
      do_beat("b4.0", 32'h1000, 2'b10, 32'hA0A0_0000, 1'b0, 1'b0, 2'b00, 2'b01, 4'h5);
      do_beat("b4.1", 32'h1004, 2'b11, 32'hA0A0_0001, 1'b0, 1'b0, 2'b00, 2'b01, 4'h5);
      do_beat("b4.2", 32'h1008, 2'b11, 32'hA0A0_0002, 1'b0, 1'b0, 2'b00, 2'b01, 4'h5);
      do_beat("b4.3", 32'h100C, 2'b11, 32'hA0A0_0003, 1'b0, 1'b1, 2'b00, 2'b00, 4'h5);
      chk("b4.end_ar_ready", ar_ready, 1);
      chk("b4.end_r_valid", r_valid, 0);

      // single byte beat
      start_ar("b1", 32'h23, 4'd0, 3'd0, 4'h9);
      do_beat("b1.0", 32'h23, 2'b10, 32'h0000_00EE, 1'b0, 1'b1, 2'b00, 2'b00, 4'h9);
      chk("b1.ar_ready_next", ar_ready, 1);
      chk("b1.r_last_after", r_last, 0);

      // hready wait states in ADDR and in DATA
      start_ar("ws", 32'h2000, 4'd1, 3'd2, 4'h3);
      for (int i = 0; i < 3; i++) begin
         hready = 1'b0;
         @(negedge clk);
         chk("ws.addr_haddr", haddr, 32'h2000);
         chk("ws.addr_htrans", htrans, 2'b10);
      end
      hready = 1'b1;
      @(negedge clk);
      chk("ws.data_htrans", htrans, 2'b00);
      for (int i = 0; i < 3; i++) begin
         hready = 1'b0;
         hrdata = 32'hBAD0_0000 + 32'(i);
         @(negedge clk);
         chk("ws.data_htrans_wait", htrans, 2'b00);
         chk("ws.data_r_valid_wait", r_valid, 0);
      end
      hready = 1'b1;
      hrdata = 32'h600D_0000;
      @(negedge clk);
      hrdata = 32'hDEAD_DEAD;
      chk("ws.r_data", r_data, 32'h600D_0000);
      chk("ws.r_last", r_last, 0);
      chk("ws.htrans_hold", htrans, 2'b01);
      r_ready = 1'b1;
      @(negedge clk);
      r_ready = 1'b0;
      do_beat("ws.1", 32'h2004, 2'b11, 32'h600D_0001, 1'b0, 1'b1, 2'b00, 2'b00, 4'h3);

      // r_ready backpressure on beat 1 of a 3-beat halfword burst
      start_ar("bp", 32'h3000, 4'd2, 3'd1, 4'hC);
      do_beat("bp.0", 32'h3000, 2'b10, 32'h1111_0000, 1'b0, 1'b0, 2'b00, 2'b01, 4'hC);
      chk("bp.1.haddr", haddr, 32'h3002);
      chk("bp.1.htrans", htrans, 2'b11);
      @(negedge clk);
      hrdata = 32'h1111_0001;
      @(negedge clk);
      hrdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         chk("bp.hold_r_valid", r_valid, 1);
         chk("bp.hold_r_data", r_data, 32'h1111_0001);
         chk("bp.hold_r_last", r_last, 0);
         chk("bp.hold_htrans", htrans, 2'b01);
         chk("bp.hold_haddr", haddr, 32'h3002);
         @(negedge clk);
      end
      chk("bp.hold_end_r_valid", r_valid, 1);
      r_ready = 1'b1;
      @(negedge clk);
      r_ready = 1'b0;
      do_beat("bp.2", 32'h3004, 2'b11, 32'h1111_0002, 1'b0, 1'b1, 2'b00, 2'b00, 4'hC);

      // hresp on beat 1
      start_ar("er", 32'h0000_0100, 4'd2, 3'd2, 4'h1);
      do_beat("er.0", 32'h100, 2'b10, 32'hE000_0000, 1'b0, 1'b0, 2'b00, 2'b01, 4'h1);
      do_beat("er.1", 32'h104, 2'b11, 32'hE000_0001, 1'b1, 1'b0, EXP_ERR_RESP, 2'b01, 4'h1);
      do_beat("er.2", 32'h108, 2'b11, 32'hE000_0002, 1'b0, 1'b1, 2'b00, 2'b00, 4'h1);

      // address wrap at the top of the 32-bit space
      start_ar("wr", 32'hFFFF_FFFC, 4'd1, 3'd2, 4'h2);
      do_beat("wr.0", 32'hFFFF_FFFC, 2'b10, 32'h0000_0AAA, 1'b0, 1'b0, 2'b00, 2'b01, 4'h2);
      do_beat("wr.1", 32'h0000_0000, 2'b11, 32'h0000_0BBB, 1'b0, 1'b1, 2'b00, 2'b00, 4'h2);

      // reset during DATA of beat 2
      start_ar("ra", 32'h4000, 4'd3, 3'd2, 4'h7);
      do_beat("ra.0", 32'h4000, 2'b10, 32'h4444_0000, 1'b0, 1'b0, 2'b00, 2'b01, 4'h7);
      do_beat("ra.1", 32'h4004, 2'b11, 32'h4444_0001, 1'b0, 1'b0, 2'b00, 2'b01, 4'h7);
      chk("ra.2.haddr", haddr, 32'h4008);
      @(negedge clk);
      chk("ra.2.htrans_data", htrans, 2'b00);
      hrdata = 32'h4444_0002;
      #2 resetn = 1'b0;
      #1 chk_reset("ra.async");
      #1 resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ra.post_r_valid", r_valid, 0);
         chk("ra.post_htrans", htrans, 2'b00);
      end
      start_ar("ra.new", 32'h5000, 4'd0, 3'd2, 4'hA);
      do_beat("ra.new.0", 32'h5000, 2'b10, 32'h5555_5555, 1'b0, 1'b1, 2'b00, 2'b00, 4'hA);
      chk("ra.new.ar_ready", ar_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
